// File: rtl/mdu_iter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mdu_iter_if : E-stage request / result bundle for the iterative MDU.  |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
interface mdu_iter_if #(
    parameter int XLEN = 32
);
    logic            StartE;
    logic            FlushE;
    logic [2:0]      funct3E;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic [4:0]      RdE;
    logic            MDUStall;
    logic            MDUBusy;
    logic            MDUDone;
    logic [XLEN-1:0] MDUResult;
    logic [4:0]      MDURd;

    modport master (
        output StartE, FlushE, funct3E, SrcAE, SrcBE, RdE,
        input  MDUStall, MDUBusy, MDUDone, MDUResult, MDURd
    );

    modport slave (
        input  StartE, FlushE, funct3E, SrcAE, SrcBE, RdE,
        output MDUStall, MDUBusy, MDUDone, MDUResult, MDURd
    );
endinterface
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mdu_iter : iterative RV32M multiply/divide, BPC bits per cycle.       |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module mdu_iter #(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    mdu_iter_if.slave   bus
);
    localparam int c_N  = XLEN / BPC;
    localparam int c_CW = $clog2(c_N) + 1;

    generate
        if ((XLEN % 2) != 0 || (BPC != 1 && BPC != 2 && BPC != 4) || (XLEN % BPC) != 0) begin : g_bad_param
            $error("mdu_iter: illegal XLEN/BPC combination");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

    state_t              r_state, w_next_state;
    logic                w_accept, w_stall, w_busy, w_done;
    logic [2:0]          r_f3;
    logic                r_neg;
    logic [XLEN-1:0]     r_b;
    logic [2*XLEN-1:0]   r_acc;
    logic [c_CW-1:0]     r_cnt;
    logic [XLEN-1:0]     r_result;
    logic [4:0]          r_rd;

    // Operand conditioning at accept time
    logic            w_a_signed, w_b_signed, w_sign_a, w_sign_b, w_special;
    logic [XLEN-1:0] w_abs_a, w_abs_b, w_special_result;
    logic            w_div_zero, w_div_ovf;

    assign w_a_signed = (bus.funct3E == 3'b001) | (bus.funct3E == 3'b010) |
                        (bus.funct3E == 3'b100) | (bus.funct3E == 3'b110);
    assign w_b_signed = (bus.funct3E == 3'b001) | (bus.funct3E == 3'b100) |
                        (bus.funct3E == 3'b110);
    assign w_sign_a   = w_a_signed & bus.SrcAE[XLEN-1];
    assign w_sign_b   = w_b_signed & bus.SrcBE[XLEN-1];
    assign w_abs_a    = w_sign_a ? -bus.SrcAE : bus.SrcAE;
    assign w_abs_b    = w_sign_b ? -bus.SrcBE : bus.SrcBE;
    assign w_div_zero = (bus.SrcBE == '0);
    assign w_div_ovf  = ~bus.funct3E[0] & (bus.SrcAE == {1'b1, {(XLEN-1){1'b0}}}) &
                        (bus.SrcBE == '1);
    assign w_special  = bus.funct3E[2] & (w_div_zero | w_div_ovf);
    assign w_special_result = w_div_zero ? (bus.funct3E[1] ? bus.SrcAE : '1)
                                         : (bus.funct3E[1] ? '0 : bus.SrcAE);

    // BPC shift-add or restoring-subtract steps on {hi, lo}
    logic [XLEN-1:0] w_hi, w_lo;
    logic [XLEN:0]   w_sum, w_r2, w_diff;

    always_comb begin
        w_hi   = r_acc[2*XLEN-1:XLEN];
        w_lo   = r_acc[XLEN-1:0];
        w_sum  = '0;
        w_r2   = '0;
        w_diff = '0;
        for (int i = 0; i < BPC; i++) begin
            if (r_f3[2]) begin
                w_r2   = {w_hi, w_lo[XLEN-1]};
                w_diff = w_r2 - {1'b0, r_b};
                w_lo   = {w_lo[XLEN-2:0], ~w_diff[XLEN]};
                w_hi   = w_diff[XLEN] ? w_r2[XLEN-1:0] : w_diff[XLEN-1:0];
            end else begin
                w_sum  = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
                w_lo   = {w_sum[0], w_lo[XLEN-1:1]};
                w_hi   = w_sum[XLEN:1];
            end
        end
    end

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_final;
    logic              w_last;

    assign w_prod  = r_neg ? -{w_hi, w_lo} : {w_hi, w_lo};
    assign w_quo   = r_neg ? -w_lo : w_lo;
    assign w_rem   = r_neg ? -w_hi : w_hi;
    assign w_final = r_f3[2] ? (r_f3[1] ? w_rem : w_quo)
                             : ((r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
    assign w_last  = (r_cnt == c_CW'(c_N - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_stall      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.StartE && !bus.FlushE) begin
                    w_accept     = 1'b1;
                    w_stall      = 1'b1;
                    w_next_state = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                w_stall = 1'b1;
                w_busy  = 1'b1;
                if (bus.FlushE)  w_next_state = S_IDLE;
                else if (w_last) w_next_state = S_DONE;
            end
            S_DONE: begin
                w_busy       = 1'b1;
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_f3     <= '0;
            r_neg    <= 1'b0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_rd     <= '0;
        end else if (w_accept) begin
            r_f3  <= bus.funct3E;
            // REM takes the dividend's sign; everything else the product of signs
            r_neg <= (bus.funct3E[2:1] == 2'b11) ? w_sign_a : (w_sign_a ^ w_sign_b);
            r_b   <= w_abs_b;
            r_acc <= {{XLEN{1'b0}}, w_abs_a};
            r_cnt <= '0;
            r_rd  <= bus.RdE;
            if (w_special) r_result <= w_special_result;
        end else if (r_state == S_CALC) begin
            if (bus.FlushE) begin
                r_rd <= '0;
            end else begin
                r_acc <= {w_hi, w_lo};
                r_cnt <= r_cnt + 1'b1;
                if (w_last) r_result <= w_final;
            end
        end
    end

    assign bus.MDUStall  = w_stall;
    assign bus.MDUBusy   = w_busy;
    assign bus.MDUDone   = w_done;
    assign bus.MDUResult = r_result;
    assign bus.MDURd     = r_rd;
endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mdu_iter : randomized + directed check of mdu_iter vs RV32M model. |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
module tb_mdu_iter;
    localparam int c_N = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mdu_iter_if #(.XLEN(32)) bus ();
    mdu_iter_if #(.XLEN(32)) bus4 ();

    mdu_iter #(.XLEN(32), .BPC(1)) dut  (.clk(clk), .rst(rst), .bus(bus));
    mdu_iter #(.XLEN(32), .BPC(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    int total = 0;
    int bad   = 0;
    logic [36:0] exp_q [$];
    logic [36:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        logic        ovf;
        logic [31:0] r;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        case (f3)
            3'd0: begin p = ua * ub; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : (ovf ? 32'h0 : 32'($signed(a) % $signed(b)));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        return f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Result checker: every MDUDone pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        #1;
        if (rst && bus.MDUDone) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result", bus.MDUResult, mon_e[31:0]);
                chk("rd", {27'b0, bus.MDURd}, {27'b0, mon_e[36:32]});
            end
        end
    end

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp);
        int cyc, stalls, want;
        want = is_special(f3, a, b) ? 1 : c_N + 1;
        @(negedge clk);
        bus.StartE  = 1'b1;
        bus.FlushE  = 1'b0;
        bus.funct3E = f3;
        bus.SrcAE   = a;
        bus.SrcBE   = b;
        bus.RdE     = rd;
        exp_q.push_back({rd, exp});
        stalls = 0;
        for (cyc = 0; cyc < 100; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (bus.MDUStall) stalls++;
            if (bus.MDUDone) break;
        end
        chk("latency", 32'(cyc), 32'(want));
        chk("stall_cycles", 32'(stalls), 32'(want));
        @(negedge clk);
        bus.StartE = 1'b0;
        #1;
        chk("done_one_cycle", {31'b0, bus.MDUDone}, 32'h0);
        chk("busy_after", {31'b0, bus.MDUBusy}, 32'h0);
    endtask

    logic [2:0]  d_f3  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] d_a   [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b   [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                                32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};

    initial begin
        int stalls, cyc;
        logic [2:0]  f3;
        logic [31:0] a, b;
        bus.StartE = 0; bus.FlushE = 0; bus.funct3E = 0; bus.SrcAE = 0; bus.SrcBE = 0; bus.RdE = 0;
        bus4.StartE = 0; bus4.FlushE = 0; bus4.funct3E = 0; bus4.SrcAE = 0; bus4.SrcBE = 0; bus4.RdE = 0;
        #2;
        chk("reset_busy",   {31'b0, bus.MDUBusy}, 32'h0);
        chk("reset_done",   {31'b0, bus.MDUDone}, 32'h0);
        chk("reset_result", bus.MDUResult, 32'h0);
        chk("reset_rd",     {27'b0, bus.MDURd}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            chk($sformatf("pin_model_%0d", i), ref_mdu(d_f3[i], d_a[i], d_b[i]), d_exp[i]);
            run_op(d_f3[i], d_a[i], d_b[i], 5'(i + 3), d_exp[i]);
        end

        // Start and flush together: ignored
        @(negedge clk);
        bus.StartE = 1'b1; bus.FlushE = 1'b1; bus.funct3E = 3'd0; bus.SrcAE = 3; bus.SrcBE = 4;
        #1;
        chk("start_flush_stall", {31'b0, bus.MDUStall}, 32'h0);
        @(negedge clk);
        bus.StartE = 1'b0; bus.FlushE = 1'b0;
        #1;
        chk("start_flush_busy", {31'b0, bus.MDUBusy}, 32'h0);

        // Flush on the 10th CALC cycle
        @(negedge clk);
        bus.StartE = 1'b1; bus.funct3E = 3'd5; bus.SrcAE = 32'd1000; bus.SrcBE = 32'd7; bus.RdE = 5'd9;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 10) bus.FlushE = 1'b1;
            #1;
            chk("flush_no_done", {31'b0, bus.MDUDone}, 32'h0);
        end
        @(negedge clk);
        bus.StartE = 1'b0; bus.FlushE = 1'b0;
        #1;
        chk("flush_busy", {31'b0, bus.MDUBusy}, 32'h0);
        chk("flush_done", {31'b0, bus.MDUDone}, 32'h0);
        run_op(3'd5, 32'd9, 32'd3, 5'd17, 32'd3);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        bus.StartE = 1'b1; bus.funct3E = 3'd0; bus.SrcAE = 32'd11; bus.SrcBE = 32'd13; bus.RdE = 5'd4;
        repeat (5) @(negedge clk);
        #2;
        bus.StartE = 1'b0;
        rst = 1'b0;
        #1;
        chk("arst_busy",   {31'b0, bus.MDUBusy}, 32'h0);
        chk("arst_stall",  {31'b0, bus.MDUStall}, 32'h0);
        chk("arst_done",   {31'b0, bus.MDUDone}, 32'h0);
        chk("arst_result", bus.MDUResult, 32'h0);
        chk("arst_rd",     {27'b0, bus.MDURd}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("arst_idle", {31'b0, bus.MDUBusy}, 32'h0);

        // Radix-16 instance
        @(negedge clk);
        bus4.StartE = 1'b1; bus4.funct3E = 3'd0; bus4.SrcAE = 32'd7; bus4.SrcBE = 32'hFFFF_FFFD; bus4.RdE = 5'd21;
        stalls = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (bus4.MDUStall) stalls++;
            if (bus4.MDUDone) break;
        end
        chk("bpc4_stall",  32'(stalls), 32'd9);
        chk("bpc4_done",   {31'b0, bus4.MDUDone}, 32'h1);
        chk("bpc4_result", bus4.MDUResult, 32'hFFFF_FFEB);
        chk("bpc4_rd",     {27'b0, bus4.MDURd}, 32'd21);
        @(negedge clk);
        bus4.StartE = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 150; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run_op(f3, a, b, 5'($urandom), ref_mdu(f3, a, b));
        end

        @(negedge clk);
        #2;
        chk("pending_results", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
